// File: rtl/deser_stream_if.sv
// Parallel-word output stream of the deserializer: word, valid-bit count, valid/ready.
// A word moves only on a cycle where deser_data_val_o and deser_data_ready_i are both 1.
interface deser_stream_if #(
    parameter int DATA_W = 16
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] deser_data_o;
    logic [CNT_W-1:0]  deser_data_mod_o;
    logic              deser_data_val_o;
    logic              deser_data_ready_i;

    modport master (
        output deser_data_o,
        output deser_data_mod_o,
        output deser_data_val_o,
        input  deser_data_ready_i
    );

    modport slave (
        input  deser_data_o,
        input  deser_data_mod_o,
        input  deser_data_val_o,
        output deser_data_ready_i
    );
endinterface

// File: rtl/deser_stream.sv
// Serial-to-parallel converter: one accumulator plus one output register, with flush of
// partial words and a single pending slot when the output register is stalled.
module deser_stream #(
    parameter int DATA_W    = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk_i,
    input  logic           srst_i,
    input  logic           data_i,
    input  logic           data_val_i,
    input  logic           flush_i,
    output logic           busy_o,
    output logic           ovf_o,
    deser_stream_if.master deser
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] TOP_POS  = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] out_data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  out_mod_q;
    logic [CNT_W-1:0]  wr_pos;
    logic              pend_q;
    logic              out_val_q;
    logic              accept;
    logic              complete;
    logic              out_xfer;
    logic              out_free;

    always_comb begin
        accept   = data_val_i && !pend_q;
        out_xfer = out_val_q && deser.deser_data_ready_i;
        out_free = !out_val_q || out_xfer;
        wr_pos   = MSB_FIRST ? (TOP_POS - cnt_q) : cnt_q;

        acc_d = acc_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (accept && (CNT_W'(i) == wr_pos)) begin
                acc_d[i] = data_i;
            end
        end
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, accept};

        // A flush only closes a word that holds at least one bit, counting this cycle's bit.
        complete = !pend_q && ((cnt_d == FULL_CNT) || (flush_i && (cnt_d != '0)));

        busy_o = pend_q || (cnt_q != '0);
        ovf_o  = data_val_i && pend_q && !srst_i;
    end

    assign deser.deser_data_o     = out_data_q;
    assign deser.deser_data_mod_o = out_mod_q;
    assign deser.deser_data_val_o = out_val_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            out_data_q <= '0;
            out_mod_q  <= '0;
            out_val_q  <= 1'b0;
        end else begin
            if (out_xfer) begin
                out_val_q <= 1'b0;
            end

            if (pend_q) begin
                // Pending word drains into the output register once it frees up.
                if (out_free) begin
                    out_data_q <= acc_q;
                    out_mod_q  <= cnt_q;
                    out_val_q  <= 1'b1;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    pend_q     <= 1'b0;
                end
            end else if (complete) begin
                if (out_free) begin
                    out_data_q <= acc_d;
                    out_mod_q  <= cnt_d;
                    out_val_q  <= 1'b1;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                end else begin
                    acc_q  <= acc_d;
                    cnt_q  <= cnt_d;
                    pend_q <= 1'b1;
                end
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end
        end
    end
endmodule
